// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Purpose  : Data-memory request/response bus between the multicycle core's
//            control unit (master) and the memory-side responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
    parameter int AW = 64
);
    logic          REQ;
    logic          DMEM_RW;
    logic [1:0]    SIZE;
    logic [AW-1:0] ADDR;
    logic [63:0]   WDATA;
    logic [63:0]   RDATA;
    logic          ACK;
    logic          ERR;
    logic          BUSY;
    logic [1:0]    ESTADO_ATUAL;

    // Control-unit side: issues requests, waits for ACK
    modport master (
        output REQ, DMEM_RW, SIZE, ADDR, WDATA,
        input  RDATA, ACK, ERR, BUSY, ESTADO_ATUAL
    );

    // Memory side: accepts requests, returns ACK with data or error
    modport slave (
        input  REQ, DMEM_RW, SIZE, ADDR, WDATA,
        output RDATA, ACK, ERR, BUSY, ESTADO_ATUAL
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Memory-side responder for the core's data-memory port. Accepts a
//            load/store, waits WAIT_CYCLES, performs the access on a byte-
//            addressed little-endian store and returns a one-cycle ACK with
//            zero-extended read data or an error flag.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int AW          = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic       CLK,
    input  wire logic       RESET,
    dmem_responder_if.slave bus
);

    localparam int          c_IW   = $clog2(DEPTH);
    localparam int          c_CW   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_WAIT = 2'd1;
    localparam logic [1:0]  c_RESP = 2'd2;
    localparam logic [c_CW-1:0] c_WAIT_LOAD = c_CW'(WAIT_CYCLES);
    localparam logic [AW:0]     c_DEPTH_X   = (AW + 1)'(DEPTH);

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_CW-1:0] r_cnt;

    // Request fields captured at acceptance
    logic            r_rw;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [63:0]     r_wdata;

    // Registered response
    logic            r_ack;
    logic            r_err;
    logic [63:0]     r_rdata;

    logic [7:0]      r_mem [DEPTH];

    // Operation that executes on the edge entering RESP. With zero wait
    // states that edge is the accepting edge itself, so the fields come
    // straight from the bus (the same values being latched on that edge).
    logic            w_op_rw;
    logic [1:0]      w_op_size;
    logic [AW-1:0]   w_op_addr;
    logic [63:0]     w_op_wdata;
    logic [3:0]      w_nbytes;
    logic [2:0]      w_align_mask;
    logic [AW:0]     w_end;
    logic            w_misaligned;
    logic            w_oor;
    logic            w_err;
    logic            w_access;
    logic [63:0]     w_rd_data;

    assign w_op_rw    = (r_state == c_IDLE) ? bus.DMEM_RW : r_rw;
    assign w_op_size  = (r_state == c_IDLE) ? bus.SIZE    : r_size;
    assign w_op_addr  = (r_state == c_IDLE) ? bus.ADDR    : r_addr;
    assign w_op_wdata = (r_state == c_IDLE) ? bus.WDATA   : r_wdata;

    assign w_nbytes     = 4'd1 << w_op_size;
    assign w_align_mask = 3'(w_nbytes - 4'd1);
    assign w_misaligned = (w_op_addr[2:0] & w_align_mask) != 3'd0;
    // End address is formed one bit wider than ADDR so it can never wrap
    assign w_end        = {1'b0, w_op_addr} + (AW + 1)'(w_nbytes);
    assign w_oor        = w_end > c_DEPTH_X;
    assign w_err        = w_misaligned | w_oor;
    assign w_access     = (w_next == c_RESP) && (r_state != c_RESP);

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.REQ) begin
                    w_next = (WAIT_CYCLES == 0) ? c_RESP : c_WAIT;
                end
            end
            c_WAIT: begin
                if (r_cnt <= c_CW'(1)) begin
                    w_next = c_RESP;
                end
            end
            c_RESP:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request capture on acceptance and wait-state countdown
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cnt   <= '0;
            r_rw    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if ((r_state == c_IDLE) && bus.REQ) begin
            r_cnt   <= c_WAIT_LOAD;
            r_rw    <= bus.DMEM_RW;
            r_size  <= bus.SIZE;
            r_addr  <= bus.ADDR;
            r_wdata <= bus.WDATA;
        end else if (r_state == c_WAIT) begin
            r_cnt   <= r_cnt - c_CW'(1);
        end
    end

    // Little-endian read assembly, unused upper bytes left at zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < w_nbytes) begin
                w_rd_data[8*i +: 8] = r_mem[w_op_addr[c_IW-1:0] + c_IW'(i)];
            end
        end
    end

    // Store write; suppressed on error and when reset coincides with RESP entry
    always_ff @(posedge CLK) begin
        if (w_access && !RESET && w_op_rw && !w_err) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < w_nbytes) begin
                    r_mem[w_op_addr[c_IW-1:0] + c_IW'(i)] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers: populated only for the single RESP cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else if (w_access) begin
            r_ack   <= 1'b1;
            r_err   <= w_err;
            r_rdata <= (w_err || w_op_rw) ? 64'd0 : w_rd_data;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end
    end

    assign bus.ACK          = r_ack;
    assign bus.ERR          = r_err;
    assign bus.RDATA        = r_rdata;
    assign bus.BUSY         = (r_state == c_WAIT) || (r_state == c_RESP);
    assign bus.ESTADO_ATUAL = r_state;

endmodule
`default_nettype wire
